// File: rtl/sdrc_bank_arb_pkg.sv
// Shared SDRAM controller definitions: command opcodes and common widths.
package sdrc_define;
  localparam int SDR_REQ_ID_W = 4;

  typedef enum logic [1:0] {
    OP_PRE = 2'b00,
    OP_ACT = 2'b01,
    OP_RD  = 2'b10,
    OP_WR  = 2'b11
  } sdr_op_e;
endpackage

// File: rtl/sdrc_bank_arb_if.sv
// Bank-FSM / transfer-controller bus around the bank arbiter.
interface sdrc_bank_arb_if #(
  parameter int APP_RW   = 9,
  parameter int REQ_ID_W = 4
);
  logic [3:0]            b2a_req;
  logic [7:0]            b2a_cmd;
  logic [47:0]           b2a_addr;
  logic [4*REQ_ID_W-1:0] b2a_id;
  logic [4*APP_RW-1:0]   b2a_len;
  logic [3:0]            b2a_start;
  logic [3:0]            b2a_last;
  logic [3:0]            b2a_wrap;
  logic [3:0]            a2b_ack;

  logic                  a2x_req;
  logic [1:0]            a2x_ba;
  logic [1:0]            a2x_cmd;
  logic [11:0]           a2x_addr;
  logic [REQ_ID_W-1:0]   a2x_id;
  logic [APP_RW-1:0]     a2x_len;
  logic                  a2x_start;
  logic                  a2x_last;
  logic                  a2x_wrap;
  logic                  x2a_ack;
  logic [3:0]            trrd_delay;

  modport slave (
    input  b2a_req, b2a_cmd, b2a_addr, b2a_id, b2a_len, b2a_start, b2a_last,
           b2a_wrap, x2a_ack, trrd_delay,
    output a2b_ack, a2x_req, a2x_ba, a2x_cmd, a2x_addr, a2x_id, a2x_len,
           a2x_start, a2x_last, a2x_wrap
  );

  modport master (
    output b2a_req, b2a_cmd, b2a_addr, b2a_id, b2a_len, b2a_start, b2a_last,
           b2a_wrap, x2a_ack, trrd_delay,
    input  a2b_ack, a2x_req, a2x_ba, a2x_cmd, a2x_addr, a2x_id, a2x_len,
           a2x_start, a2x_last, a2x_wrap
  );
endinterface

// File: rtl/sdrc_bank_arb_rr_pick4.sv
// Combinational 4-way round-robin picker: first set mask bit at or after i_start.
module sdrc_rr_pick4 (
  input  logic [3:0] i_mask,
  input  logic [1:0] i_start,
  output logic       o_vld,
  output logic [1:0] o_idx
);
  logic [1:0] w_cand;

  // Walk the ring backwards so the candidate closest to i_start is written last.
  always_comb begin
    o_idx  = '0;
    w_cand = '0;
    for (int k = 3; k >= 0; k--) begin
      w_cand = i_start + 2'(k);
      if (i_mask[w_cand]) o_idx = w_cand;
    end
  end

  assign o_vld = |i_mask;
endmodule

// File: rtl/sdrc_bank_arb.sv
// Four-bank command arbiter: starved-row > transfer > row priority, round-robin
// within a group, with ACT-to-ACT (tRRD) spacing. Grant is purely combinational.
module sdrc_bank_arb
  import sdrc_define::*;
#(
  parameter int APP_RW   = 9,
  parameter int REQ_ID_W = SDR_REQ_ID_W,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  sdrc_bank_arb_if.slave   bus
);
  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [1:0]          w_cmd  [4];
  logic [11:0]         w_addr [4];
  logic [REQ_ID_W-1:0] w_id   [4];
  logic [APP_RW-1:0]   w_len  [4];
  logic [3:0]          w_row;
  logic [3:0]          w_elig;
  logic [3:0]          w_starved;
  logic [3:0]          w_ack;

  logic [3:0]          r_wait [4];
  logic [1:0]          r_rr_ptr;
  logic [3:0]          r_trrd_cnt;
  logic                w_trrd_ok;

  logic                w_stv_vld, w_xfr_vld, w_row_vld;
  logic [1:0]          w_stv_idx, w_xfr_idx, w_row_idx;
  logic                w_gnt_vld;
  logic [1:0]          w_gnt;
  logic                w_acc;

  assign w_trrd_ok = (r_trrd_cnt == 4'd0);

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    assign w_cmd[gi]  = bus.b2a_cmd[2*gi +: 2];
    assign w_addr[gi] = bus.b2a_addr[12*gi +: 12];
    assign w_id[gi]   = bus.b2a_id[REQ_ID_W*gi +: REQ_ID_W];
    assign w_len[gi]  = bus.b2a_len[APP_RW*gi +: APP_RW];
    // PRE/ACT share a zero MSB
    assign w_row[gi]  = ~w_cmd[gi][1];
    // Reset gating here keeps every output quiet while reset_n is low.
    assign w_elig[gi] = reset_n & bus.b2a_req[gi] &
                        ~((w_cmd[gi] == OP_ACT) & ~w_trrd_ok);
    assign w_starved[gi] = w_elig[gi] & w_row[gi] & (r_wait[gi] == LP_MAX_WAIT);

    // A tRRD-blocked ACT is still a pending row request, so it holds its count.
    always_ff @(posedge clk) begin
      if (!reset_n)                             r_wait[gi] <= '0;
      else if (w_ack[gi])                       r_wait[gi] <= '0;
      else if (bus.b2a_req[gi] && w_row[gi]) begin
        if (w_elig[gi] && r_wait[gi] != LP_MAX_WAIT) r_wait[gi] <= r_wait[gi] + 4'd1;
      end
      else                                      r_wait[gi] <= '0;
    end
  end

  sdrc_rr_pick4 u_pick_stv (.i_mask(w_starved),          .i_start(r_rr_ptr),
                            .o_vld(w_stv_vld), .o_idx(w_stv_idx));
  sdrc_rr_pick4 u_pick_xfr (.i_mask(w_elig & ~w_row),    .i_start(r_rr_ptr),
                            .o_vld(w_xfr_vld), .o_idx(w_xfr_idx));
  sdrc_rr_pick4 u_pick_row (.i_mask(w_elig & w_row),     .i_start(r_rr_ptr),
                            .o_vld(w_row_vld), .o_idx(w_row_idx));

  always_comb begin
    w_gnt = w_row_idx;
    if (w_stv_vld)      w_gnt = w_stv_idx;
    else if (w_xfr_vld) w_gnt = w_xfr_idx;
  end

  assign w_gnt_vld = w_stv_vld | w_xfr_vld | w_row_vld;
  assign w_acc     = bus.x2a_ack & w_gnt_vld;
  assign w_ack     = w_acc ? (4'b0001 << w_gnt) : 4'b0000;

  assign bus.a2b_ack   = w_ack;
  assign bus.a2x_req   = w_gnt_vld;
  assign bus.a2x_ba    = w_gnt_vld ? w_gnt                     : '0;
  assign bus.a2x_cmd   = w_gnt_vld ? w_cmd[w_gnt]              : '0;
  assign bus.a2x_addr  = w_gnt_vld ? w_addr[w_gnt]             : '0;
  assign bus.a2x_id    = w_gnt_vld ? w_id[w_gnt]               : '0;
  assign bus.a2x_len   = w_gnt_vld ? w_len[w_gnt]              : '0;
  assign bus.a2x_start = w_gnt_vld & bus.b2a_start[w_gnt];
  assign bus.a2x_last  = w_gnt_vld & bus.b2a_last[w_gnt];
  assign bus.a2x_wrap  = w_gnt_vld & bus.b2a_wrap[w_gnt];

  always_ff @(posedge clk) begin
    if (!reset_n)   r_rr_ptr <= '0;
    else if (w_acc) r_rr_ptr <= w_gnt + 2'd1;
  end

  // An accepted ACT reloads even when the counter is already idle.
  always_ff @(posedge clk) begin
    if (!reset_n)                                r_trrd_cnt <= '0;
    else if (w_acc && w_cmd[w_gnt] == OP_ACT)    r_trrd_cnt <= bus.trrd_delay;
    else if (r_trrd_cnt != 4'd0)                 r_trrd_cnt <= r_trrd_cnt - 4'd1;
  end
endmodule

// File: tb/tb_sdrc_bank_arb.sv
// Scoreboard bench for sdrc_bank_arb: directed cycles push expected outputs,
// a negedge monitor pops and compares.
module tb_sdrc_bank_arb;
  localparam int APP_RW   = 9;
  localparam int REQ_ID_W = 4;
  localparam logic [1:0] PRE = 2'b00, ACT = 2'b01, RD = 2'b10, WR = 2'b11;

  typedef struct packed {
    logic          req;
    logic [1:0]    ba;
    logic [1:0]    cmd;
    logic [11:0]   addr;
    logic [3:0]    id;
    logic [8:0]    len;
    logic          start;
    logic          last;
    logic          wrap;
    logic [3:0]    ack;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q_exp[$];
  string q_name[$];

  sdrc_bank_arb_if #(.APP_RW(APP_RW), .REQ_ID_W(REQ_ID_W)) bus ();

  sdrc_bank_arb #(.APP_RW(APP_RW), .REQ_ID_W(REQ_ID_W), .MAX_WAIT(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] addr_of(input logic [1:0] b);
    case (b)
      2'd0: return 12'h100;
      2'd1: return 12'h255;
      2'd2: return 12'h01A;
      default: return 12'hABC;
    endcase
  endfunction

  function automatic logic [8:0] len_of(input logic [1:0] b);
    case (b)
      2'd0: return 9'd1;
      2'd1: return 9'd4;
      2'd2: return 9'd7;
      default: return 9'd10;
    endcase
  endfunction

  function automatic logic [7:0] cv(input logic [1:0] c3, c2, c1, c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic step(input string nm, input logic rst, input logic [3:0] req,
                      input logic [7:0] cmd, input logic ack, input logic e_req,
                      input logic [1:0] e_ba, input logic [1:0] e_cmd,
                      input logic [3:0] e_ack);
    exp_t e;
    logic [3:0] st_tab, la_tab, wr_tab;
    st_tab = 4'b0101;
    la_tab = 4'b0011;
    wr_tab = 4'b1000;
    @(posedge clk);
    #1;
    reset_n     = rst;
    bus.b2a_req = req;
    bus.b2a_cmd = cmd;
    bus.x2a_ack = ack;
    e = '0;
    if (e_req) begin
      e.req   = 1'b1;
      e.ba    = e_ba;
      e.cmd   = e_cmd;
      e.addr  = addr_of(e_ba);
      e.id    = 4'd5 + 4'(e_ba);
      e.len   = len_of(e_ba);
      e.start = st_tab[e_ba];
      e.last  = la_tab[e_ba];
      e.wrap  = wr_tab[e_ba];
    end
    e.ack = e_ack;
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      a  = {bus.a2x_req, bus.a2x_ba, bus.a2x_cmd, bus.a2x_addr, bus.a2x_id,
            bus.a2x_len, bus.a2x_start, bus.a2x_last, bus.a2x_wrap, bus.a2b_ack};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got req=%b ba=%0d cmd=%b addr=%h id=%h len=%0d s/l/w=%b%b%b ack=%b, expected req=%b ba=%0d cmd=%b addr=%h id=%h len=%0d s/l/w=%b%b%b ack=%b",
                    nm, a.req, a.ba, a.cmd, a.addr, a.id, a.len, a.start, a.last, a.wrap, a.ack,
                    e.req, e.ba, e.cmd, e.addr, e.id, e.len, e.start, e.last, e.wrap, e.ack);
    end
  end

  initial begin
    logic [7:0] all_rd, cls, trv, stv;
    logic [1:0] rr_seq [5];
    logic [1:0] stv_seq [10];
    all_rd = cv(RD, RD, RD, RD);
    cls    = cv(RD, RD, WR, ACT);
    trv    = cv(RD, PRE, ACT, ACT);
    stv    = cv(PRE, RD, RD, RD);
    rr_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    stv_seq = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd3, 2'd0};

    bus.b2a_req    = '0;
    bus.b2a_cmd    = '0;
    bus.b2a_addr   = {12'hABC, 12'h01A, 12'h255, 12'h100};
    bus.b2a_id     = {4'd8, 4'd7, 4'd6, 4'd5};
    bus.b2a_len    = {9'd10, 9'd7, 9'd4, 9'd1};
    bus.b2a_start  = 4'b0101;
    bus.b2a_last   = 4'b0011;
    bus.b2a_wrap   = 4'b1000;
    bus.x2a_ack    = 1'b0;
    bus.trrd_delay = 4'd0;

    step("reset0", 1'b0, 4'hF, all_rd, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
    step("reset1", 1'b0, 4'hF, all_rd, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);

    for (int i = 0; i < 5; i++)
      step("rr_fair", 1'b1, 4'hF, all_rd, 1'b1, 1'b1, rr_seq[i], RD, 4'b0001 << rr_seq[i]);

    step("reset_mid", 1'b0, 4'hF, all_rd, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
    step("post_reset", 1'b1, 4'hF, all_rd, 1'b1, 1'b1, 2'd0, RD, 4'b0001);

    step("single_b2", 1'b1, 4'b0100, all_rd, 1'b1, 1'b1, 2'd2, RD, 4'b0100);
    step("rr_after_b2", 1'b1, 4'hF, all_rd, 1'b0, 1'b1, 2'd3, RD, 4'b0000);

    step("reset_cls", 1'b0, 4'hF, all_rd, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
    step("cls_wr_first", 1'b1, 4'b0011, cls, 1'b1, 1'b1, 2'd1, WR, 4'b0010);
    step("cls_act_next", 1'b1, 4'b0001, cls, 1'b1, 1'b1, 2'd0, ACT, 4'b0001);

    step("ack_no_req", 1'b1, 4'b0000, all_rd, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
    step("rr_hold", 1'b1, 4'hF, all_rd, 1'b0, 1'b1, 2'd1, RD, 4'b0000);

    bus.trrd_delay = 4'd3;
    step("trrd_act0", 1'b1, 4'b0001, trv, 1'b1, 1'b1, 2'd0, ACT, 4'b0001);
    step("trrd_pre_ok", 1'b1, 4'b0110, trv, 1'b1, 1'b1, 2'd2, PRE, 4'b0100);
    step("trrd_blk12", 1'b1, 4'b0010, trv, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
    step("trrd_blk13", 1'b1, 4'b0010, trv, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
    step("trrd_act1", 1'b1, 4'b0010, trv, 1'b1, 1'b1, 2'd1, ACT, 4'b0010);
    bus.trrd_delay = 4'd0;

    for (int i = 0; i < 10; i++)
      step("starve", 1'b1, 4'b1011, stv, 1'b1, 1'b1, stv_seq[i],
           (stv_seq[i] == 2'd3) ? PRE : RD, 4'b0001 << stv_seq[i]);

    step("idle", 1'b1, 4'b0000, all_rd, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);

    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
    if (q_exp.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries left, required 0", q_exp.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sdrc_bank_arb.md
# sdrc_bank_arb

Four-bank command arbiter between the per-bank FSMs and the transfer controller. Each bank FSM presents one command (PRE/ACT/RD/WR) with its row/column address and burst attributes. The arbiter picks one bank per cycle and forwards its command to the transfer controller with a 2-bit bank address, then routes the transfer controller's acknowledge back to the winning bank. It enforces the activate-to-activate spacing (tRRD) and prevents row commands from being starved by back-to-back transfers.

## Interface
- APP_RW, 9, request length width
- REQ_ID_W, 4, request ID width
- MAX_WAIT, 8, cycles a row command (PRE/ACT) may be denied before it is promoted; range 1..15
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- b2a_req  in  4  per-bank request, bit i = bank i
- b2a_cmd  in  8  per-bank command, bank i in bits [2i+1:2i]
- b2a_addr  in  48  per-bank row/col address, bank i in [12i+11:12i]
- b2a_id  in  4*REQ_ID_W  per-bank request ID
- b2a_len  in  4*APP_RW  per-bank length
- b2a_start / b2a_last / b2a_wrap  in  4 each  per-bank burst flags
- a2b_ack  out  4  one-hot acknowledge to the granted bank
- a2x_req  out  1  request to transfer controller
- a2x_ba  out  2  bank address of granted bank
- a2x_cmd  out  2  granted command
- a2x_addr  out  12  granted address
- a2x_id, a2x_len, a2x_start, a2x_last, a2x_wrap  out  as inputs  granted attributes
- x2a_ack  in  1  transfer controller accepted a2x_* this cycle
- trrd_delay  in  4  ACT-to-ACT spacing in cycles, 0 = no spacing

## Operation
- Command codes: PRE=2'b00, ACT=2'b01, RD=2'b10, WR=2'b11.
- Classes:
  - xfr = RD/WR.
  - row = PRE/ACT.
- Eligibility: eligible[i] = b2a_req[i] & ~(cmd_i==ACT & ~trrd_ok).
- Starvation: starved[i] = eligible row request with wait_cnt[i] == MAX_WAIT.
- Priority of groups, highest first: (1) starved row, (2) xfr, (3) row.
- Within a group, round-robin: search banks rr_ptr, rr_ptr+1, ... mod 4; the first eligible bank wins.
- Grant is purely combinational from the current inputs. No grant is held across cycles, because bank FSMs may drop or change requests freely.
- a2x_req = |eligible. a2x_* fields are muxed from the granted bank. When there is no grant, all a2x_* fields are 0.
- a2b_ack[g] = x2a_ack & (granted bank == g). All other a2b_ack bits are 0.
- rr_ptr: on x2a_ack, rr_ptr <= g+1 mod 4. Otherwise it holds.
- tRRD counter (4b):
  - On an accepted ACT (x2a_ack & a2x_cmd==ACT), trrd_cnt <= trrd_delay.
  - Otherwise, while nonzero, trrd_cnt decrements by 1.
  - trrd_ok = (trrd_cnt==0).
- wait_cnt[i] (4b, saturating at MAX_WAIT):
  - Increments when bank i has an eligible row request and is not acked.
  - Clears to 0 on a2b_ack[i], or when bank i's request is absent or not a row command.
  - An ACT blocked only by tRRD is not eligible, so its counter holds.
- Reset (reset_n low at a clk edge): rr_ptr=0, trrd_cnt=0, all wait_cnt=0. While reset_n is low, a2x_req=0 and a2b_ack=0 regardless of inputs.

## Timing
- Zero-cycle path: b2a_* -> a2x_* and x2a_ack -> a2b_ack are combinational within the same cycle.
- rr_ptr, trrd_cnt and wait_cnt update on the clk edge following the ack.
- ACT spacing: after an ACT is accepted in cycle N with trrd_delay=D, the next ACT can be granted no earlier than cycle N+D+1. PRE, RD and WR are never blocked by trrd_cnt.
- Simultaneous events:
  - An accepted ACT in the same cycle as trrd_cnt==0 reloads the counter; the load wins over the decrement.
  - Two starved banks: round-robin from rr_ptr decides.
- x2a_ack asserted while a2x_req=0 is ignored: no state changes and no ack is routed.
- reset_n deasserting mid-burst: the arbiter holds no burst state, so it resumes arbitration immediately.

## Structure
- Shared package (sdrc_define): OP_PRE/OP_ACT/OP_RD/OP_WR, SDR_REQ_ID_W.
- Sub-module sdrc_rr_pick4: combinational 4-input round-robin picker.
  - Inputs: 4-bit mask, 2-bit start pointer.
  - Outputs: valid, 2-bit index.
  - Instantiated three times, once per priority group.
- Per-bank slicing of the flattened buses is done with generate loops in this module.

## Test plan
- Single bank: bank 2 requests RD addr 0x01A, x2a_ack=1 -> a2x_ba=2, a2x_cmd=RD, a2x_addr=0x01A, a2b_ack=4'b0100 in the same cycle; rr_ptr becomes 3.
- Class priority: bank 0 requests ACT and bank 1 requests WR in the same cycle, rr_ptr=0 -> bank 1 WR granted first.
- Starvation: bank 3 requests PRE continuously while banks 0 and 1 alternate RD, every request acked, MAX_WAIT=8 -> bank 3 granted in the 9th cycle of the sequence.
- tRRD: trrd_delay=3, bank 0 ACT accepted in cycle 10, bank 1 ACT pending -> bank 1 not granted in cycles 11-13, granted in cycle 14; a bank 2 PRE is still granted in cycle 11.
- Round-robin fairness: all four banks hold RD with x2a_ack=1 every cycle from reset -> grant order 0,1,2,3,0.
- Reset mid-operation: assert reset_n=0 with all requests active -> a2x_req=0 and a2b_ack=0; after release, bank 0 is granted first.
